// File: rtl/taiga_machine_timer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp behind a single-cycle register bus.
// Optional software interrupt (msip at word 4) is built only when MTIMER_SOFT_IRQ_EN is defined.
module taiga_machine_timer #(
  parameter int unsigned TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  addr,
  input  logic [3:0]  be,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        timer_interrupt,
  output logic        soft_interrupt
);

  localparam logic [2:0]  ADDR_MTIME_LO = 3'd0;
  localparam logic [2:0]  ADDR_MTIME_HI = 3'd1;
  localparam logic [2:0]  ADDR_CMP_LO   = 3'd2;
  localparam logic [2:0]  ADDR_CMP_HI   = 3'd3;
  localparam logic [2:0]  ADDR_MSIP     = 3'd4;
  localparam logic [15:0] COUNT_MAX     = 16'(TICK_DIV - 1);

  logic [63:0] mtime, mtime_next;
  logic [63:0] mtimecmp, cmp_next;
  logic [31:0] hi_snap, snap_next;
  logic [31:0] rdata_next;
  logic [15:0] count, count_next;
  logic        tick;
  logic        wr_req, rd_req;

`ifdef MTIMER_SOFT_IRQ_EN
  logic msip;
`endif

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  byte_en);
    logic [31:0] merged;
    merged = old_val;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) merged[8*i +: 8] = new_val[8*i +: 8];
    end
    return merged;
  endfunction

  assign tick       = (count == COUNT_MAX);
  assign count_next = tick ? 16'd0 : count + 16'd1;
  assign wr_req     = req & we;
  assign rd_req     = req & ~we;

  // NOTE: every variable driven here gets a default first, so no latch can be inferred.
  always_comb begin
    mtime_next = tick ? mtime + 64'd1 : mtime;
    cmp_next   = mtimecmp;
    snap_next  = hi_snap;

    // A software write to either half of mtime replaces the tick increment for that cycle.
    if (wr_req && (be != 4'd0)) begin
      case (addr)
        ADDR_MTIME_LO: mtime_next = {mtime[63:32], merge_bytes(mtime[31:0], wdata, be)};
        ADDR_MTIME_HI: begin
          mtime_next = {merge_bytes(mtime[63:32], wdata, be), mtime[31:0]};
          snap_next  = merge_bytes(mtime[63:32], wdata, be);
        end
        ADDR_CMP_LO:   cmp_next = {mtimecmp[63:32], merge_bytes(mtimecmp[31:0], wdata, be)};
        ADDR_CMP_HI:   cmp_next = {merge_bytes(mtimecmp[63:32], wdata, be), mtimecmp[31:0]};
        default:       ;
      endcase
    end

    // Reading the low word freezes the high word so a lo-then-hi read pair is coherent.
    if (rd_req && (addr == ADDR_MTIME_LO)) snap_next = mtime[63:32];
  end

  always_comb begin
    rdata_next = 32'd0;
    if (rd_req) begin
      case (addr)
        ADDR_MTIME_LO: rdata_next = mtime[31:0];
        ADDR_MTIME_HI: rdata_next = hi_snap;
        ADDR_CMP_LO:   rdata_next = mtimecmp[31:0];
        ADDR_CMP_HI:   rdata_next = mtimecmp[63:32];
`ifdef MTIMER_SOFT_IRQ_EN
        ADDR_MSIP:     rdata_next = {31'd0, msip};
`endif
        default:       rdata_next = 32'd0;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtime           <= 64'd0;
      mtimecmp        <= '1;
      count           <= 16'd0;
      hi_snap         <= 32'd0;
      ack             <= 1'b0;
      rdata           <= 32'd0;
      timer_interrupt <= 1'b0;
    end else begin
      mtime           <= mtime_next;
      mtimecmp        <= cmp_next;
      count           <= count_next;
      hi_snap         <= snap_next;
      ack             <= req;
      rdata           <= rdata_next;
      timer_interrupt <= (mtime_next >= cmp_next);
    end
  end

`ifdef MTIMER_SOFT_IRQ_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msip           <= 1'b0;
      soft_interrupt <= 1'b0;
    end else begin
      if (wr_req && (addr == ADDR_MSIP) && be[0]) msip <= wdata[0];
      soft_interrupt <= msip;
    end
  end
`else
  assign soft_interrupt = 1'b0;
`endif

endmodule

// File: tb/tb_taiga_machine_timer.sv
// Directed bench for taiga_machine_timer: one instance with TICK_DIV=1 and one with TICK_DIV=4.
module tb_taiga_machine_timer;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        u1_req, u1_we, u1_ack, u1_tint, u1_sint;
  logic [2:0]  u1_addr;
  logic [3:0]  u1_be;
  logic [31:0] u1_wdata, u1_rdata;

  logic        u4_req, u4_we, u4_ack, u4_tint, u4_sint;
  logic [2:0]  u4_addr;
  logic [3:0]  u4_be;
  logic [31:0] u4_wdata, u4_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  taiga_machine_timer #(.TICK_DIV(1)) dut (
    .clk(clk), .rst_n(rst_n), .req(u1_req), .we(u1_we), .addr(u1_addr), .be(u1_be),
    .wdata(u1_wdata), .ack(u1_ack), .rdata(u1_rdata),
    .timer_interrupt(u1_tint), .soft_interrupt(u1_sint)
  );

  taiga_machine_timer #(.TICK_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(u4_req), .we(u4_we), .addr(u4_addr), .be(u4_be),
    .wdata(u4_wdata), .ack(u4_ack), .rdata(u4_rdata),
    .timer_interrupt(u4_tint), .soft_interrupt(u4_sint)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // One bus transaction, issued at a falling edge; returns at the next falling edge.
  task automatic bus(input bit sel, input logic w, input logic [2:0] a, input logic [3:0] b,
                     input logic [31:0] d, output logic [31:0] rd);
    if (sel) begin
      u4_req = 1'b1; u4_we = w; u4_addr = a; u4_be = b; u4_wdata = d;
    end else begin
      u1_req = 1'b1; u1_we = w; u1_addr = a; u1_be = b; u1_wdata = d;
    end
    @(posedge clk);
    @(negedge clk);
    if (sel) begin
      check("ack4", u4_ack, 1);
      rd = u4_rdata;
      u4_req = 1'b0;
    end else begin
      check("ack1", u1_ack, 1);
      rd = u1_rdata;
      u1_req = 1'b0;
    end
  endtask

  task automatic wr(input bit sel, input logic [2:0] a, input logic [3:0] b, input logic [31:0] d);
    logic [31:0] unused;
    bus(sel, 1'b1, a, b, d, unused);
  endtask

  task automatic rd_check(input bit sel, input logic [2:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] got;
    bus(sel, 1'b0, a, 4'h0, 32'h0, got);
    check(tag, got, exp);
  endtask

  task automatic wait_irq(input bit sel, input int budget, input string tag);
    int n;
    n = 0;
    while (((sel ? u4_tint : u1_tint) == 1'b0) && (n < budget)) begin
      idle(1);
      n++;
    end
    check(tag, sel ? u4_tint : u1_tint, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    u1_req = 1'b0; u1_we = 1'b0; u1_addr = 3'd0; u1_be = 4'h0; u1_wdata = 32'h0;
    u4_req = 1'b0; u4_we = 1'b0; u4_addr = 3'd0; u4_be = 4'h0; u4_wdata = 32'h0;
    idle(3);
    check("rst_ack", u1_ack, 0);
    check("rst_rdata", u1_rdata, 0);
    check("rst_tint", u1_tint, 0);
    check("rst_sint", u1_sint, 0);
    check("rst_tint4", u4_tint, 0);

    // Release on a falling edge; cycle counts below are rising edges since release.
    rst_n = 1'b1;

    // T1: after 10 edges mtime is 10
    idle(10);
    rd_check(0, 3'd0, 32'd10, "t1_mtime_lo");
    check("t1_tint", u1_tint, 0);
    rd_check(0, 3'd1, 32'd0, "t1_mtime_hi");

    // T2: compare at 20; interrupt registered on the same edge mtime becomes 20
    wr(0, 3'd3, 4'hF, 32'd0);
    wr(0, 3'd2, 4'hF, 32'd20);
    check("t2_tint_low", u1_tint, 0);
    wait_irq(0, 40, "t2_tint_rise");
    rd_check(0, 3'd0, 32'd20, "t2_mtime_at_rise");
    check("t2_tint_level", u1_tint, 1);
    wr(0, 3'd2, 4'hF, 32'hFFFF_FFFF);
    check("t2_tint_fall", u1_tint, 0);

    // T4: wrap through 2^64 and hi snapshot
    wr(0, 3'd1, 4'hF, 32'hFFFF_FFFF);
    check("t4_tint_hi_cmp", u1_tint, 1);
    wr(0, 3'd0, 4'hF, 32'hFFFF_FFFE);
    idle(3);
    rd_check(0, 3'd0, 32'd1, "t4_wrap_lo");
    check("t4_tint_after_wrap", u1_tint, 0);
    rd_check(0, 3'd1, 32'd0, "t4_wrap_hi");
    wr(0, 3'd1, 4'hF, 32'hFFFF_FFFF);
    wr(0, 3'd0, 4'hF, 32'hFFFF_FFFD);
    idle(2);
    rd_check(0, 3'd0, 32'hFFFF_FFFF, "t4_lo_before_wrap");
    idle(1);
    rd_check(0, 3'd1, 32'hFFFF_FFFF, "t4_hi_snapshot");
    rd_check(0, 3'd0, 32'd2, "t4_lo_after_wrap");
    rd_check(0, 3'd1, 32'd0, "t4_hi_resnap");

    // T5: write wins over tick, byte enables, cmp writes leave mtime alone
    wr(0, 3'd1, 4'hF, 32'd0);
    wr(0, 3'd0, 4'hF, 32'h0000_0100);
    rd_check(0, 3'd0, 32'h0000_0100, "t5_write_no_inc");
    idle(3);
    rd_check(0, 3'd0, 32'h0000_0104, "t5_elapsed");
    wr(0, 3'd0, 4'b0010, 32'h0000_AB00);
    rd_check(0, 3'd0, 32'h0000_AB05, "t5_be_byte1");
    wr(0, 3'd0, 4'b0000, 32'hFFFF_FFFF);
    rd_check(0, 3'd0, 32'h0000_AB07, "t5_be_zero");
    wr(0, 3'd2, 4'hF, 32'h0000_1234);
    rd_check(0, 3'd0, 32'h0000_AB09, "t5_cmp_no_mtime");
    rd_check(0, 3'd2, 32'h0000_1234, "t5_cmp_lo");
    rd_check(0, 3'd3, 32'h0000_0000, "t5_cmp_hi");
    check("t5_tint_cmp_low", u1_tint, 1);
    wr(0, 3'd1, 4'b1000, 32'h5A00_0000);
    rd_check(0, 3'd1, 32'h5A00_0000, "t5_hi_write_snap");

    // Reserved words and msip
    rd_check(0, 3'd5, 32'd0, "rsv5");
    wr(0, 3'd6, 4'hF, 32'hFFFF_FFFF);
    rd_check(0, 3'd6, 32'd0, "rsv6");
    rd_check(0, 3'd7, 32'd0, "rsv7");
`ifdef MTIMER_SOFT_IRQ_EN
    wr(0, 3'd4, 4'hF, 32'd1);
    check("t6_sint_lag", u1_sint, 0);
    idle(1);
    check("t6_sint_set", u1_sint, 1);
    rd_check(0, 3'd4, 32'd1, "t6_msip_read");
    wr(0, 3'd4, 4'b0001, 32'd0);
    idle(1);
    check("t6_sint_clear", u1_sint, 0);
`else
    wr(0, 3'd4, 4'hF, 32'hFFFF_FFFF);
    idle(1);
    check("t6_sint_off", u1_sint, 0);
    rd_check(0, 3'd4, 32'd0, "t6_msip_rsv");
`endif

    // Back-to-back requests give back-to-back acks, then rdata returns to 0
    u1_req = 1'b1; u1_we = 1'b0; u1_addr = 3'd2; u1_be = 4'h0;
    @(posedge clk); @(negedge clk);
    check("b2b_ack0", u1_ack, 1);
    check("b2b_rd0", u1_rdata, 32'h0000_1234);
    u1_addr = 3'd1;
    @(posedge clk); @(negedge clk);
    check("b2b_ack1", u1_ack, 1);
    check("b2b_rd1", u1_rdata, 32'h5A00_0000);
    u1_req = 1'b0;
    @(posedge clk); @(negedge clk);
    check("b2b_ack_idle", u1_ack, 0);
    check("b2b_rd_idle", u1_rdata, 0);

    // Unsigned 64-bit compare: low word above cmp_lo must not fire while hi is below
    wr(0, 3'd3, 4'hF, 32'd1);
    wr(0, 3'd2, 4'hF, 32'd0);
    wr(0, 3'd1, 4'hF, 32'd0);
    wr(0, 3'd0, 4'hF, 32'hFFFF_FFF0);
    check("cmp64_no_fire", u1_tint, 0);
    wait_irq(0, 40, "cmp64_rise");
    rd_check(0, 3'd0, 32'd0, "cmp64_lo_at_rise");
    rd_check(0, 3'd1, 32'd1, "cmp64_hi_at_rise");

    // Reset in the middle of a transaction drops the pending ack
    u1_req = 1'b1; u1_we = 1'b0; u1_addr = 3'd2;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    u1_req = 1'b0;
    #1;
    check("midrst_ack", u1_ack, 0);
    check("midrst_rdata", u1_rdata, 0);
    check("midrst_tint", u1_tint, 0);
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;

    // T3: TICK_DIV=4 -> mtime 10 after 40 edges, steps every 4th edge
    check("t3_tint4", u4_tint, 0);
    idle(40);
    rd_check(1, 3'd0, 32'd10, "t3_c40");
    rd_check(1, 3'd0, 32'd10, "t3_c41");
    rd_check(1, 3'd0, 32'd10, "t3_c42");
    rd_check(1, 3'd0, 32'd10, "t3_c43");
    rd_check(1, 3'd0, 32'd11, "t3_c44");

    // Write landing on a tick edge (edge 48) stores the value without +1
    idle(2);
    wr(1, 3'd0, 4'hF, 32'h0000_0100);
    rd_check(1, 3'd0, 32'h0000_0100, "col_c48");
    rd_check(1, 3'd0, 32'h0000_0100, "col_c49");
    rd_check(1, 3'd0, 32'h0000_0100, "col_c50");
    rd_check(1, 3'd0, 32'h0000_0100, "col_c51");
    rd_check(1, 3'd0, 32'h0000_0101, "col_c52");
    // Off-tick write (edge 54) must not restart the prescaler: next tick stays at edge 56
    wr(1, 3'd0, 4'hF, 32'h0000_0200);
    rd_check(1, 3'd0, 32'h0000_0200, "pre_c54");
    rd_check(1, 3'd0, 32'h0000_0200, "pre_c55");
    rd_check(1, 3'd0, 32'h0000_0201, "pre_c56");

    // State of the first instance after the mid-operation reset
    rd_check(0, 3'd3, 32'hFFFF_FFFF, "post_rst_cmp_hi");
    rd_check(0, 3'd2, 32'hFFFF_FFFF, "post_rst_cmp_lo");
    check("post_rst_tint", u1_tint, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
